fp_add_scheduler: RTL and testbench
===================================

FP_ADD_SCHEDULER -- requirements
Module: fp_add_scheduler

Interface
REQ-001 The block SHALL have parameter LATENCY, default 5: register stages of the external FP adder, from operand sample to result.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8: entries per result FIFO; must be at least 2.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high. Ports: clk in 1, rising-edge clock; rst in 1, async active-high reset.
REQ-004 The block SHALL have these ports:
- req0_valid in 1, req0_ready out 1, req0_a in 32, req0_b in 32: port-0 operand handshake, IEEE-754 single-precision operands.
- req1_valid in 1, req1_ready out 1, req1_a in 32, req1_b in 32: port-1 operand handshake, same format.
- res0_valid out 1, res0_ready in 1, res0_data out 32: port-0 result handshake.
- res1_valid out 1, res1_ready in 1, res1_data out 32: port-1 result handshake.
- add_a out 32, add_b out 32, add_n in 32: connections to the shared adder (adder operand inputs and result output).
- busy out 1: set while any operation is in flight or any result is queued.

Function
REQ-005 A transfer on a request port SHALL occur on a rising edge where valid and ready are both 1; at most one transfer per edge across both ports.
REQ-006 reqK_ready SHALL be 1 only if both of these hold: port K is granted this cycle, and outstanding[K] + fifo_count[K] < FIFO_DEPTH (credit check on registered counts).
REQ-007 Arbitration SHALL be round-robin:
- only one eligible port (valid plus credit): that port wins;
- both eligible: the port other than last_grant wins;
- last_grant updates only on a transfer.
REQ-008 Operands accepted at edge E SHALL be registered and driven on add_a/add_b during the cycle after E; on cycles with no issue, add_a and add_b SHALL be 0x00000000.
REQ-009 A tag pipeline of LATENCY+1 stages (valid bit plus port id) SHALL track each issue. The op issued at edge E SHALL have add_n written into FIFO[port] at edge E+LATENCY+1.
REQ-010 Result data SHALL be passed through bit-exact. The block SHALL NOT round, normalise or check for NaN.
REQ-011 Minimum latency SHALL be LATENCY+1 edges from request transfer to resK_valid=1: with LATENCY=5, request at edge 0 gives a valid result in the cycle after edge 6.
REQ-012 outstanding[K] SHALL:
- increment on issue to K;
- decrement when a K tag is written to FIFO[K];
- stay unchanged when both happen on the same edge.
REQ-013 Each result FIFO SHALL behave as follows:
- resK_valid = FIFO[K] not empty;
- pop on resK_valid and resK_ready;
- push and pop on the same edge are both allowed, and the count is unchanged.
REQ-014 Results SHALL be in issue order per port; there is no ordering guarantee across ports.
REQ-015 A push into a full FIFO is impossible by construction (REQ-006); a bench assertion SHALL flag it.
REQ-016 busy SHALL equal the OR of all tag valid bits and both FIFO non-empty flags.
REQ-017 A pop that frees a credit at edge E SHALL allow reqK_ready=1 from the cycle after E, not in the same cycle.

Reset
REQ-018 While rst=1, the following SHALL be cleared immediately: tag valid bits, outstanding counters, FIFO pointers and counts, and the issue register (add_a/add_b=0).
REQ-019 While rst=1, last_grant SHALL be set to 1, so port 0 wins the first tie.
REQ-020 During and after reset, the output values SHALL be: req*_ready=0 while rst=1, res*_valid=0, busy=0.
REQ-021 Operations in flight at reset SHALL be discarded. add_n (the adder has no reset) SHALL be ignored until a valid tag emerges.

Structure
REQ-022 Package fp_sched_pkg SHALL hold the word width (32), default LATENCY, default FIFO_DEPTH, and the port-id type (1 bit).
REQ-023 The design SHALL contain one sub-module, fp_result_fifo (synchronous FIFO, async reset, count output), instantiated once per port.
REQ-024 The adder SHALL be instantiated outside this block; a top level wires add_a/add_b/add_n to it.

Verification
REQ-025 Single port-0 op, a=0x3F800000, b=0x40000000 at edge 0 -> res0_data=0x40400000 valid after edge 6; res1_valid stays 0; busy falls after the pop.
REQ-026 Both ports valid every cycle, res ready always 1, 20 ops each -> grants alternate 0,1,0,1,... starting with port 0, and all results return in per-port order.
REQ-027 res0_ready=0 with port 0 streaming -> exactly 8 port-0 transfers, then req0_ready=0; port 1 still accepts every cycle.
REQ-028 Continuation of REQ-027: raising res0_ready drains 8 results in order, and req0_ready returns the cycle after the first pop.
REQ-029 3 ops in flight, then a 1-cycle rst pulse -> no res*_valid ever appears for them, busy=0 immediately, and the next op completes correctly after LATENCY+1 edges.
REQ-030 Push and pop on the same edge with FIFO[0] at depth 7 -> count stays 7 and no data is lost or duplicated.

Source files
------------

// File: rtl/fp_sched_pkg.sv
// Shared definitions for the FP adder scheduler.
//   WORD_W         : operand / result word width (IEEE-754 single precision)
//   DEF_LATENCY    : default register depth of the external adder
//   DEF_FIFO_DEPTH : default entries per result FIFO
//   port_id_t      : request/result port identifier (one bit, two ports)
package fp_sched_pkg;

    localparam int WORD_W         = 32;
    localparam int DEF_LATENCY    = 5;
    localparam int DEF_FIFO_DEPTH = 8;

    typedef logic port_id_t;

    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/fp_result_fifo.sv
// Synchronous result FIFO with asynchronous active-high reset.
// Ports:
//   clk, rst  : clock, async active-high reset (clears pointers and count)
//   i_push    : write i_data this edge (ignored when full)
//   i_data    : write data
//   i_pop     : discard head entry this edge (ignored when empty)
//   o_data    : head entry, valid while o_empty is low
//   o_empty   : no entries stored
//   o_count   : number of stored entries (0..DEPTH)
module fp_result_fifo
    import fp_sched_pkg::*;
#(
    parameter  int DEPTH = DEF_FIFO_DEPTH,
    parameter  int WIDTH = WORD_W,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == {CNT_W{1'b0}});
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Two-port scheduler in front of one shared, fixed-latency FP adder.
// Requests are arbitrated round-robin, issued one per cycle to the adder,
// tracked by a tag pipeline and returned through a per-port result FIFO.
// A port is only granted while it has FIFO room reserved for every result
// it already has in flight, so a result FIFO can never overflow.
// Ports:
//   clk, rst                        : clock, async active-high reset
//   req{0,1}_valid/_ready/_a/_b     : operand handshake per port
//   res{0,1}_valid/_ready/_data     : result handshake per port
//   add_a, add_b                    : operands to the external adder
//   add_n                           : adder result, LATENCY cycles after add_a/add_b
//   busy                            : any op in flight or any result queued
module fp_add_scheduler
    import fp_sched_pkg::*;
#(
    parameter int LATENCY    = DEF_LATENCY,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WORD_W-1:0] req0_a,
    input  logic [WORD_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WORD_W-1:0] req1_a,
    input  logic [WORD_W-1:0] req1_b,
    output logic              res0_valid,
    input  logic              res0_ready,
    output logic [WORD_W-1:0] res0_data,
    output logic              res1_valid,
    input  logic              res1_ready,
    output logic [WORD_W-1:0] res1_data,
    output logic [WORD_W-1:0] add_a,
    output logic [WORD_W-1:0] add_b,
    input  logic [WORD_W-1:0] add_n,
    output logic              busy
);

    localparam int             CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] CREDIT_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    logic [CNT_W-1:0]  r_out0;
    logic [CNT_W-1:0]  r_out1;
    logic [CNT_W-1:0]  w_cnt0;
    logic [CNT_W-1:0]  w_cnt1;
    logic              w_empty0;
    logic              w_empty1;
    logic              w_push0;
    logic              w_push1;
    logic              w_pop0;
    logic              w_pop1;
    logic              w_credit0;
    logic              w_credit1;
    logic              w_elig0;
    logic              w_elig1;
    logic              w_xfer;
    port_id_t          w_gnt;
    logic              w_inc0;
    logic              w_inc1;
    port_id_t          r_last_grant;
    logic [LATENCY:0]  r_tag_vld;
    logic [LATENCY:0]  r_tag_port;
    logic [WORD_W-1:0] r_add_a;
    logic [WORD_W-1:0] r_add_b;

    // Credit: in-flight ops plus queued results must leave a free FIFO slot.
    // Both terms are registered, so a pop frees credit only from the next cycle.
    assign w_credit0 = ({1'b0, r_out0} + {1'b0, w_cnt0}) < CREDIT_LIM;
    assign w_credit1 = ({1'b0, r_out1} + {1'b0, w_cnt1}) < CREDIT_LIM;
    assign w_elig0   = req0_valid && w_credit0 && !rst;
    assign w_elig1   = req1_valid && w_credit1 && !rst;

    // Round-robin grant: a tie goes to the port that did not win last time.
    always_comb begin
        w_xfer = 1'b0;
        w_gnt  = PORT0;
        if (w_elig0 && w_elig1) begin
            w_xfer = 1'b1;
            w_gnt  = ~r_last_grant;
        end else if (w_elig0) begin
            w_xfer = 1'b1;
            w_gnt  = PORT0;
        end else if (w_elig1) begin
            w_xfer = 1'b1;
            w_gnt  = PORT1;
        end else begin
            w_xfer = 1'b0;
            w_gnt  = PORT0;
        end
    end

    assign req0_ready = w_xfer && (w_gnt == PORT0);
    assign req1_ready = w_xfer && (w_gnt == PORT1);
    assign w_inc0     = req0_ready;
    assign w_inc1     = req1_ready;

    // Issue register feeding the adder; idles at zero between issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_add_a      <= {WORD_W{1'b0}};
            r_add_b      <= {WORD_W{1'b0}};
            r_last_grant <= PORT1;
        end else if (w_xfer) begin
            r_add_a      <= (w_gnt == PORT1) ? req1_a : req0_a;
            r_add_b      <= (w_gnt == PORT1) ? req1_b : req0_b;
            r_last_grant <= w_gnt;
        end else begin
            r_add_a      <= {WORD_W{1'b0}};
            r_add_b      <= {WORD_W{1'b0}};
            r_last_grant <= r_last_grant;
        end
    end

    assign add_a = r_add_a;
    assign add_b = r_add_b;

    // Tag pipeline: stage 0 mirrors the issue register, stage LATENCY lines
    // up with add_n, so its tag steers the result into the right FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld  <= {(LATENCY + 1){1'b0}};
            r_tag_port <= {(LATENCY + 1){1'b0}};
        end else begin
            r_tag_vld  <= {r_tag_vld[LATENCY-1:0], w_xfer};
            r_tag_port <= {r_tag_port[LATENCY-1:0], w_gnt};
        end
    end

    assign w_push0 = r_tag_vld[LATENCY] && (r_tag_port[LATENCY] == PORT0);
    assign w_push1 = r_tag_vld[LATENCY] && (r_tag_port[LATENCY] == PORT1);

    // Outstanding-op counters: +1 on issue, -1 when the result lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out0 <= {CNT_W{1'b0}};
            r_out1 <= {CNT_W{1'b0}};
        end else begin
            case ({w_inc0, w_push0})
                2'b10:   r_out0 <= r_out0 + CNT_W'(1);
                2'b01:   r_out0 <= r_out0 - CNT_W'(1);
                default: r_out0 <= r_out0;
            endcase
            case ({w_inc1, w_push1})
                2'b10:   r_out1 <= r_out1 + CNT_W'(1);
                2'b01:   r_out1 <= r_out1 - CNT_W'(1);
                default: r_out1 <= r_out1;
            endcase
        end
    end

    assign res0_valid = !w_empty0;
    assign res1_valid = !w_empty1;
    assign w_pop0     = res0_valid && res0_ready;
    assign w_pop1     = res1_valid && res1_ready;

    fp_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo0 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push0),
        .i_data  (add_n),
        .i_pop   (w_pop0),
        .o_data  (res0_data),
        .o_empty (w_empty0),
        .o_count (w_cnt0)
    );

    fp_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push1),
        .i_data  (add_n),
        .i_pop   (w_pop1),
        .o_data  (res1_data),
        .o_empty (w_empty1),
        .o_count (w_cnt1)
    );

    assign busy = (|r_tag_vld) || !w_empty0 || !w_empty1;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Self-checking bench for fp_add_scheduler with a behavioural LATENCY-stage
// adder (positive normal operands, truncating) standing in for the real one.
module tb_fp_add_scheduler;

    localparam int LAT   = 5;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        res0_valid, res0_ready, res1_valid, res1_ready;
    logic [31:0] res0_data, res1_data;
    logic [31:0] add_a, add_b, add_n;
    logic        busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          xf0 = 0, xf1 = 0, pop0 = 0, pop1 = 0;
    logic [31:0] exp0 [$];
    logic [31:0] exp1 [$];
    logic [31:0] add_pipe [LAT];

    always #5 clk = ~clk;

    fp_add_scheduler #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_data(res0_data),
        .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_data(res1_data),
        .add_a(add_a), .add_b(add_b), .add_n(add_n), .busy(busy)
    );

    // Single-precision add for positive normal (or zero) operands, truncating.
    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] hi, lo;
        logic [7:0]  e, sh;
        logic [24:0] mh, ml, s;
        if (x[30:0] == 31'd0) return y;
        if (y[30:0] == 31'd0) return x;
        hi = (y[30:23] > x[30:23]) ? y : x;
        lo = (y[30:23] > x[30:23]) ? x : y;
        e  = hi[30:23];
        sh = hi[30:23] - lo[30:23];
        mh = {2'b01, hi[22:0]};
        ml = {2'b01, lo[22:0]};
        ml = (sh > 8'd24) ? 25'd0 : (ml >> sh);
        s  = mh + ml;
        if (s[24]) begin
            s = s >> 1;
            e = e + 8'd1;
        end
        return {1'b0, e, s[22:0]};
    endfunction

    function automatic logic [31:0] gen_a(input int p, input int n);
        return 32'h3F800000 | (32'(n) << 15) | (32'(p) << 14);
    endfunction

    function automatic logic [31:0] gen_b(input int p, input int n);
        return 32'h40000000 | (32'(n) << 13) | (32'(p) << 12);
    endfunction

    function automatic logic [31:0] b2w(input logic b);
        return {31'd0, b};
    endfunction

    // External adder model: LAT register stages, deliberately without reset.
    always @(posedge clk) begin
        add_pipe[0] <= fp_add(add_a, add_b);
        for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign add_n = add_pipe[LAT-1];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // A push into a full result FIFO must never happen.
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("push_full0", b2w(dut.w_push0 && (32'(dut.w_cnt0) == DEPTH)), 32'd0);
            check_eq("push_full1", b2w(dut.w_push1 && (32'(dut.w_cnt1) == DEPTH)), 32'd0);
        end
    end

    // Scoreboard at the sampling point: record transfers, check pops in order.
    task automatic sb();
        if (req0_valid && req0_ready) begin exp0.push_back(fp_add(req0_a, req0_b)); xf0++; end
        if (req1_valid && req1_ready) begin exp1.push_back(fp_add(req1_a, req1_b)); xf1++; end
        if (res0_valid && exp0.size() == 0) check_eq("res0_spurious", b2w(res0_valid), 32'd0);
        else if (res0_valid && res0_ready) begin check_eq("res0_data", res0_data, exp0.pop_front()); pop0++; end
        if (res1_valid && exp1.size() == 0) check_eq("res1_spurious", b2w(res1_valid), 32'd0);
        else if (res1_valid && res1_ready) begin check_eq("res1_data", res1_data, exp1.pop_front()); pop1++; end
    endtask

    task automatic fin();
        sb();
        @(posedge clk);
        #1;
        req0_a = gen_a(0, xf0); req0_b = gen_b(0, xf0);
        req1_a = gen_a(1, xf1); req1_b = gen_b(1, xf1);
    endtask

    task automatic cyc();
        @(negedge clk);
        fin();
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        rst = 1'b1;
        #1;
        check_eq("rst_busy",  b2w(busy), 32'd0);
        check_eq("rst_add_a", add_a, 32'd0);
        check_eq("rst_rdy0",  b2w(req0_ready), 32'd0);
        check_eq("rst_rdy1",  b2w(req1_ready), 32'd0);
        check_eq("rst_rv0",   b2w(res0_valid), 32'd0);
        exp0.delete(); exp1.delete();
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One isolated op on port p: latency, adder drive, result and busy.
    task automatic single_op(input logic p, input logic [31:0] exp_res);
        logic [31:0] ea, eb;
        res0_ready = 1'b0; res1_ready = 1'b0;
        ea = p ? req1_a : req0_a;
        eb = p ? req1_b : req0_b;
        if (p) req1_valid = 1'b1; else req0_valid = 1'b1;
        @(negedge clk);
        check_eq("op_ready", b2w(p ? req1_ready : req0_ready), 32'd1);
        fin();                                       // edge E
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check_eq("op_add_a", add_a, ea);
        check_eq("op_add_b", add_b, eb);
        check_eq("op_busy",  b2w(busy), 32'd1);
        fin();                                       // edge E+1
        repeat (4) cyc();                            // edges E+2..E+5
        @(negedge clk);
        check_eq("op_early", b2w(p ? res1_valid : res0_valid), 32'd0);
        fin();                                       // edge E+6
        @(negedge clk);
        check_eq("op_valid", b2w(p ? res1_valid : res0_valid), 32'd1);
        check_eq("op_data",  p ? res1_data : res0_data, exp_res);
        check_eq("op_other", b2w(p ? res0_valid : res1_valid), 32'd0);
        check_eq("op_busy_q", b2w(busy), 32'd1);
        if (p) res1_ready = 1'b1; else res0_ready = 1'b1;
        fin();                                       // pop
        @(negedge clk);
        check_eq("op_popped", b2w(p ? res1_valid : res0_valid), 32'd0);
        check_eq("op_idle",   b2w(busy), 32'd0);
        res0_ready = 1'b0; res1_ready = 1'b0;
        fin();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int k, s0, sp0, c0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        res0_ready = 1'b0; res1_ready = 1'b0;
        req0_a = gen_a(0, 0); req0_b = gen_b(0, 0);
        req1_a = gen_a(1, 0); req1_b = gen_b(1, 0);

        // Reset state
        #1 rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        check_eq("reset_rdy0", b2w(req0_ready), 32'd0);
        check_eq("reset_rdy1", b2w(req1_ready), 32'd0);
        check_eq("reset_rv0",  b2w(res0_valid), 32'd0);
        check_eq("reset_rv1",  b2w(res1_valid), 32'd0);
        check_eq("reset_busy", b2w(busy), 32'd0);
        check_eq("reset_add_a", add_a, 32'd0);
        check_eq("reset_add_b", add_b, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1.0 + 2.0 on port 0 = 3.0
        single_op(1'b0, 32'h40400000);

        // Three ops in flight, then a reset pulse discards them
        res0_ready = 1'b1; res1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (3) cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check_eq("inflight_busy", b2w(busy), 32'd1);
        pulse_rst();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq("post_rst_rv0", b2w(res0_valid), 32'd0);
            check_eq("post_rst_rv1", b2w(res1_valid), 32'd0);
            fin();
        end
        single_op(1'b0, fp_add(req0_a, req0_b));

        // Both ports streaming from a fresh reset: strict alternation from port 0
        pulse_rst();
        res0_ready = 1'b1; res1_ready = 1'b1;
        s0 = xf0; c0 = xf1; sp0 = pop0; k = 0;
        for (int c = 0; c < 200; c++) begin
            if (xf0 - s0 >= 20 && xf1 - c0 >= 20 && exp0.size() == 0 && exp1.size() == 0) break;
            req0_valid = (xf0 - s0 < 20);
            req1_valid = (xf1 - c0 < 20);
            @(negedge clk);
            if (req0_valid && req1_valid) begin
                check_eq("alt_grant", {30'd0, req1_ready, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
                k++;
            end
            fin();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check_eq("alt_xf0",  32'(xf0 - s0), 32'd20);
        check_eq("alt_xf1",  32'(xf1 - c0), 32'd20);
        check_eq("alt_pop0", 32'(pop0 - sp0), 32'd20);
        check_eq("alt_left", 32'(exp0.size() + exp1.size()), 32'd0);

        // Port 0 results held back: exactly DEPTH transfers, port 1 keeps flowing
        res0_ready = 1'b0; res1_ready = 1'b1;
        s0 = xf0;
        for (int c = 0; c < 30; c++) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            @(negedge clk);
            if (xf0 - s0 == DEPTH) begin
                check_eq("full_rdy0", b2w(req0_ready), 32'd0);
                check_eq("full_rdy1", b2w(req1_ready), 32'd1);
            end
            fin();
        end
        check_eq("full_xf0", 32'(xf0 - s0), 32'd8);

        // Release port 0 results: credit returns the cycle after the first pop
        req1_valid = 1'b0; req0_valid = 1'b1;
        sp0 = pop0;
        @(negedge clk);
        res0_ready = 1'b1;
        check_eq("drain_rdy0_same", b2w(req0_ready), 32'd0);
        check_eq("drain_rv0", b2w(res0_valid), 32'd1);
        fin();
        @(negedge clk);
        check_eq("drain_rdy0_next", b2w(req0_ready), 32'd1);
        req0_valid = 1'b0;
        fin();
        repeat (12) cyc();
        check_eq("drain_pops", 32'(pop0 - sp0), 32'd8);
        check_eq("drain_left", 32'(exp0.size()), 32'd0);

        // FIFO 0 at 7 entries: push and pop on the same edge
        res0_ready = 1'b0;
        s0 = xf0; sp0 = pop0;
        req0_valid = 1'b1;
        for (int c = 0; c < 20 && (xf0 - s0) < 7; c++) cyc();
        cyc();                                       // eighth op, edge E8
        req0_valid = 1'b0;
        repeat (5) cyc();                            // edges E8+1..E8+5
        @(negedge clk);
        check_eq("pp_cnt_before", 32'(dut.w_cnt0), 32'd7);
        res0_ready = 1'b1;
        fin();                                       // edge E8+6: push + pop
        @(negedge clk);
        check_eq("pp_cnt_after", 32'(dut.w_cnt0), 32'd7);
        fin();
        repeat (12) cyc();
        check_eq("pp_pops", 32'(pop0 - sp0), 32'd8);
        check_eq("pp_left", 32'(exp0.size()), 32'd0);
        check_eq("pp_busy", b2w(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
